// File: rtl/credit_port_buffer_if.sv
// Upstream, downstream and status bundle for credit_port_buffer.
// master = traffic source/sink side, slave = the buffer itself.
interface credit_port_buffer_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int N_PORTS    = 5
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [N_PORTS-1:0]                 rx;
  logic [N_PORTS-1:0][FLIT_WIDTH-1:0] data_i;
  logic [N_PORTS-1:0]                 credit_o;

  logic [N_PORTS-1:0]                 tx;
  logic [N_PORTS-1:0][FLIT_WIDTH-1:0] data_o;
  logic [N_PORTS-1:0]                 credit_i;

  logic [N_PORTS-1:0][OCC_W-1:0]      occupancy;
  logic [N_PORTS-1:0]                 overflow;
  logic [N_PORTS-1:0][15:0]           flit_count;

  modport master (
    output rx, data_i, credit_i,
    input  credit_o, tx, data_o, occupancy, overflow, flit_count
  );

  modport slave (
    input  rx, data_i, credit_i,
    output credit_o, tx, data_o, occupancy, overflow, flit_count
  );
endinterface

// File: rtl/credit_port_buffer.sv
// N_PORTS independent credit-flow FIFOs, DEPTH flits each (DEPTH a power of two).
// Define CREDIT_PORT_BUFFER_STATS_EN to build the saturating per-port flit counters.
module credit_port_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int N_PORTS    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  credit_port_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;
    logic                  r_overflow;

    logic w_credit;
    logic w_tx;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Credit and valid depend only on registered occupancy: no rx-to-tx path.
    assign w_credit = (r_occ < FULL_OCC);
    assign w_tx     = (r_occ != '0);
    assign w_push   = bus.rx[p] & w_credit;
    assign w_pop    = w_tx & bus.credit_i[p];
    assign w_drop   = bus.rx[p] & ~w_credit;

    // NOTE: flit storage is deliberately left out of reset; occupancy gates
    // every read, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.data_i[p];
    end

    // NOTE: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_occ      <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        unique case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
        if (w_drop) r_overflow <= 1'b1;
      end
    end

    assign bus.credit_o[p]  = w_credit;
    assign bus.tx[p]        = w_tx;
    assign bus.data_o[p]    = r_mem[r_rd_ptr];
    assign bus.occupancy[p] = r_occ;
    assign bus.overflow[p]  = r_overflow;

`ifdef CREDIT_PORT_BUFFER_STATS_EN
    logic [15:0] r_flit_count;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_flit_count <= '0;
      end else if (w_push && (r_flit_count != 16'hFFFF)) begin
        r_flit_count <= r_flit_count + 16'd1;
      end
    end

    assign bus.flit_count[p] = r_flit_count;
`else
    assign bus.flit_count[p] = '0;
`endif
  end
endmodule

// File: tb/tb_credit_port_buffer.sv
// Scoreboard bench for credit_port_buffer: per-port reference queues plus
// scenario tasks for fill, drain order, wrap, isolation, reset and stats.
module tb_credit_port_buffer;
  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int NP    = 5;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  credit_port_buffer_if #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .N_PORTS(NP)) bus ();

  credit_port_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .N_PORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] sb_q [NP][$];
  logic [NP-1:0] m_ovf;
  logic [15:0]   m_cnt [NP];

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      sb_q[p].delete();
      m_cnt[p] = 16'd0;
    end
    m_ovf = '0;
  endtask

  // One clock: compare every port against the reference, apply the
  // stimulus across the next rising edge, then update the reference.
  task automatic sb_cycle(input logic [NP-1:0] rx_v,
                          input logic [NP-1:0][FW-1:0] d_v,
                          input logic [NP-1:0] ci_v);
    logic [NP-1:0] push;
    logic [NP-1:0] pop;
    bus.rx       = rx_v;
    bus.data_i   = d_v;
    bus.credit_i = ci_v;
    for (int p = 0; p < NP; p++) begin
      int n;
      n = sb_q[p].size();
      total++;
      if (bus.occupancy[p] !== OCC_W'(n)) begin
        bad++; $display("FAIL occupancy p%0d: got %0d exp %0d", p, bus.occupancy[p], n);
      end
      total++;
      if (bus.credit_o[p] !== (n < DEPTH)) begin
        bad++; $display("FAIL credit_o p%0d: got %b exp %b", p, bus.credit_o[p], (n < DEPTH));
      end
      total++;
      if (bus.tx[p] !== (n != 0)) begin
        bad++; $display("FAIL tx p%0d: got %b exp %b", p, bus.tx[p], (n != 0));
      end
      if (n != 0) begin
        total++;
        if (bus.data_o[p] !== sb_q[p][0]) begin
          bad++; $display("FAIL data_o p%0d: got %h exp %h", p, bus.data_o[p], sb_q[p][0]);
        end
      end
      total++;
      if (bus.overflow[p] !== m_ovf[p]) begin
        bad++; $display("FAIL overflow p%0d: got %b exp %b", p, bus.overflow[p], m_ovf[p]);
      end
      total++;
      if (bus.flit_count[p] !== m_cnt[p]) begin
        bad++; $display("FAIL flit_count p%0d: got %h exp %h", p, bus.flit_count[p], m_cnt[p]);
      end
      push[p] = rx_v[p] && (n < DEPTH);
      pop[p]  = ci_v[p] && (n != 0);
      if (rx_v[p] && (n >= DEPTH)) m_ovf[p] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (pop[p]) void'(sb_q[p].pop_front());
      if (push[p]) begin
        sb_q[p].push_back(d_v[p]);
`ifdef CREDIT_PORT_BUFFER_STATS_EN
        if (m_cnt[p] != 16'hFFFF) m_cnt[p] = m_cnt[p] + 16'd1;
`endif
      end
    end
  endtask

  task automatic idle_inputs();
    bus.rx       = '0;
    bus.data_i   = '0;
    bus.credit_i = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    idle_inputs();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_clear();
    rst = 1'b1;
    #3;
    total++;
    if (bus.tx !== '0) begin bad++; $display("FAIL reset_tx: got %b exp 0", bus.tx); end
    total++;
    if (bus.credit_o !== '1) begin bad++; $display("FAIL reset_credit: got %b exp all 1", bus.credit_o); end
    total++;
    if (bus.occupancy !== '0) begin bad++; $display("FAIL reset_occ: got %h exp 0", bus.occupancy); end
    total++;
    if (bus.overflow !== '0) begin bad++; $display("FAIL reset_ovf: got %b exp 0", bus.overflow); end
    total++;
    if (bus.flit_count !== '0) begin bad++; $display("FAIL reset_cnt: got %h exp 0", bus.flit_count); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (bus.tx !== '0 || bus.credit_o !== '1) begin
      bad++; $display("FAIL post_reset: tx=%b credit=%b exp tx=0 credit=all 1", bus.tx, bus.credit_o);
    end
  endtask

  task automatic test_fill_drain();
    logic [NP-1:0][FW-1:0] d;
    d = '0;
    for (int i = 1; i <= 5; i++) begin
      d[0] = 32'hA000_0000 + i;
      sb_cycle(5'b00001, d, 5'b00000);
      if (i == 4) begin
        total++;
        if (bus.credit_o[0] !== 1'b0) begin bad++; $display("FAIL fill_credit: got %b exp 0", bus.credit_o[0]); end
        total++;
        if (bus.occupancy[0] !== OCC_W'(4)) begin bad++; $display("FAIL fill_occ: got %0d exp 4", bus.occupancy[0]); end
        total++;
        if (bus.overflow[0] !== 1'b0) begin bad++; $display("FAIL fill_early_ovf: got %b exp 0", bus.overflow[0]); end
      end
    end
    total++;
    if (bus.overflow[0] !== 1'b1) begin bad++; $display("FAIL fill_ovf: got %b exp 1", bus.overflow[0]); end
    total++;
    if (bus.occupancy[0] !== OCC_W'(4)) begin bad++; $display("FAIL fill_drop_occ: got %0d exp 4", bus.occupancy[0]); end
    d = '0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (bus.data_o[0] !== 32'hA000_0000 + k) begin
        bad++; $display("FAIL drain_order k%0d: got %h exp %h", k, bus.data_o[0], 32'hA000_0000 + k);
      end
      sb_cycle(5'b00000, d, 5'b00001);
    end
    total++;
    if (bus.tx[0] !== 1'b0 || bus.occupancy[0] !== '0) begin
      bad++; $display("FAIL drain_empty: tx=%b occ=%0d exp tx=0 occ=0", bus.tx[0], bus.occupancy[0]);
    end
    total++;
    if (bus.overflow[0] !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b exp 1", bus.overflow[0]); end
  endtask

  task automatic test_simultaneous();
    logic [NP-1:0][FW-1:0] d;
    do_reset();
    d = '0;
    for (int i = 0; i < 2; i++) begin
      d[0] = 32'h100 + i;
      sb_cycle(5'b00001, d, 5'b00000);
    end
    for (int i = 0; i < 10; i++) begin
      d[0] = i;
      sb_cycle(5'b00001, d, 5'b00001);
      total++;
      if (bus.occupancy[0] !== OCC_W'(2)) begin
        bad++; $display("FAIL simul_occ i%0d: got %0d exp 2", i, bus.occupancy[0]);
      end
    end
    d = '0;
    for (int i = 0; i < 4; i++) sb_cycle(5'b00000, d, 5'b00001);
    total++;
    if (bus.occupancy[0] !== '0 || bus.tx[0] !== 1'b0) begin
      bad++; $display("FAIL empty_pop: occ=%0d tx=%b exp occ=0 tx=0", bus.occupancy[0], bus.tx[0]);
    end
    // Full with pop on the same edge: push must still be refused.
    for (int i = 0; i < 4; i++) begin
      d[0] = 32'h200 + i;
      sb_cycle(5'b00001, d, 5'b00000);
    end
    d[0] = 32'hDEAD;
    sb_cycle(5'b00001, d, 5'b00001);
    total++;
    if (bus.occupancy[0] !== OCC_W'(3) || bus.overflow[0] !== 1'b1) begin
      bad++; $display("FAIL full_pop_push: occ=%0d ovf=%b exp occ=3 ovf=1", bus.occupancy[0], bus.overflow[0]);
    end
    d = '0;
    for (int i = 0; i < 3; i++) sb_cycle(5'b00000, d, 5'b00001);
  endtask

  task automatic test_isolation();
    logic [NP-1:0][FW-1:0] d;
    do_reset();
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d[3] = 32'h3000 + i;
      sb_cycle(5'b01000, d, 5'b00000);
    end
    for (int p = 0; p < NP; p++) begin
      if (p != 3) begin
        total++;
        if (bus.occupancy[p] !== '0 || bus.overflow[p] !== 1'b0 || bus.tx[p] !== 1'b0) begin
          bad++; $display("FAIL isolation p%0d: occ=%0d ovf=%b tx=%b exp all 0",
                          p, bus.occupancy[p], bus.overflow[p], bus.tx[p]);
        end
      end
    end
    total++;
    if (bus.overflow[3] !== 1'b1 || bus.occupancy[3] !== OCC_W'(4)) begin
      bad++; $display("FAIL isolation_p3: occ=%0d ovf=%b exp occ=4 ovf=1", bus.occupancy[3], bus.overflow[3]);
    end
  endtask

  task automatic test_reset_mid();
    logic [NP-1:0][FW-1:0] d;
    do_reset();
    d = '0;
    for (int i = 0; i < 5; i++) begin
      d[1] = 32'h1100 + i;
      d[4] = 32'h4400 + i;
      sb_cycle((i < 3) ? 5'b10010 : 5'b10000, d, 5'b00000);
    end
    total++;
    if (bus.occupancy[1] !== OCC_W'(3) || bus.overflow[4] !== 1'b1) begin
      bad++; $display("FAIL pre_reset: occ1=%0d ovf4=%b exp occ1=3 ovf4=1", bus.occupancy[1], bus.overflow[4]);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.occupancy !== '0) begin bad++; $display("FAIL mid_reset_occ: got %h exp 0", bus.occupancy); end
    total++;
    if (bus.tx !== '0) begin bad++; $display("FAIL mid_reset_tx: got %b exp 0", bus.tx); end
    total++;
    if (bus.overflow !== '0) begin bad++; $display("FAIL mid_reset_ovf: got %b exp 0", bus.overflow); end
    total++;
    if (bus.credit_o !== '1) begin bad++; $display("FAIL mid_reset_credit: got %b exp all 1", bus.credit_o); end
    model_clear();
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    d = '0;
    for (int i = 0; i < 3; i++) sb_cycle(5'b00000, d, 5'b11111);
  endtask

  task automatic test_stats();
    logic [NP-1:0][FW-1:0] d;
    do_reset();
    d = '0;
`ifdef CREDIT_PORT_BUFFER_STATS_EN
    for (int i = 0; i < 70000; i++) begin
      d[2] = i;
      sb_cycle(5'b00100, d, 5'b00100);
    end
    total++;
    if (bus.flit_count[2] !== 16'hFFFF) begin
      bad++; $display("FAIL stats_sat: got %h exp ffff", bus.flit_count[2]);
    end
    total++;
    if (bus.flit_count[0] !== 16'h0 || bus.flit_count[4] !== 16'h0) begin
      bad++; $display("FAIL stats_other: p0=%h p4=%h exp 0", bus.flit_count[0], bus.flit_count[4]);
    end
`else
    for (int i = 0; i < 20; i++) begin
      d[2] = i;
      sb_cycle(5'b00100, d, 5'b00100);
    end
    total++;
    if (bus.flit_count !== '0) begin
      bad++; $display("FAIL stats_tied: got %h exp 0", bus.flit_count);
    end
`endif
    d = '0;
    sb_cycle(5'b00000, d, 5'b11111);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_isolation();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/credit_port_buffer.md
CREDIT_PORT_BUFFER -- requirements
Module: credit_port_buffer

Interface
REQ-001 The block SHALL have parameter FLIT_WIDTH, default 32, flit width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, flits per port FIFO, power of two, at least 2.
REQ-003 The block SHALL have parameter N_PORTS, default 5, number of independent channels.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clock  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have these upstream ports: rx  input  N_PORTS  flit-valid per port; data_i  input  N_PORTS x FLIT_WIDTH  incoming flit per port; credit_o  output  N_PORTS  space available per port.
REQ-006 The block SHALL have these downstream ports: tx  output  N_PORTS  flit-valid per port; data_o  output  N_PORTS x FLIT_WIDTH  head flit per port; credit_i  input  N_PORTS  downstream can accept.
REQ-007 The block SHALL have these status ports: occupancy  output  N_PORTS x $clog2(DEPTH+1)  flits held per port; overflow  output  N_PORTS  sticky drop flag; flit_count  output  N_PORTS x 16  accepted-flit counter.

Function
REQ-008 Each port SHALL be an independent FIFO with read pointer, write pointer and counter; ports SHALL share no state.
REQ-009 credit_o[p] SHALL equal (occupancy[p] < DEPTH), combinationally from registered state.
REQ-010 A push SHALL occur on a rising edge when rx[p]=1 and credit_o[p]=1; data_i[p] is written at the write pointer, which then increments modulo DEPTH.
REQ-011 tx[p] SHALL equal (occupancy[p] != 0); data_o[p] SHALL present the flit at the read pointer.
REQ-012 A pop SHALL occur on a rising edge when tx[p]=1 and credit_i[p]=1; the read pointer increments modulo DEPTH.
REQ-013 A flit pushed at edge N SHALL appear on data_o/tx after edge N when the FIFO was empty; there is no combinational rx-to-tx bypass.
REQ-014 Simultaneous push and pop SHALL leave occupancy unchanged; push alone adds 1; pop alone subtracts 1.
REQ-015 When full, a push SHALL be refused even if a pop occurs on the same edge, because credit_o is low.
REQ-016 rx[p]=1 while credit_o[p]=0 SHALL drop the flit, leave the FIFO unchanged, and set overflow[p], which stays set until reset.
REQ-017 When empty, credit_i[p]=1 SHALL have no effect; pointers and occupancy stay unchanged.
REQ-018 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.

Reset
REQ-019 Asserting reset SHALL immediately clear all pointers, occupancy, overflow and flit_count, regardless of clock.
REQ-020 During and right after reset, tx SHALL be all 0 and credit_o all 1; FIFO storage content need not be cleared.
REQ-021 Reset asserted mid-transfer SHALL discard all buffered flits; no flit SHALL appear on tx after reset deasserts until a new push.

Configuration
REQ-022 With macro CREDIT_PORT_BUFFER_STATS_EN defined, flit_count[p] SHALL increment by 1 on every accepted push and saturate at 16'hFFFF.
REQ-023 Without CREDIT_PORT_BUFFER_STATS_EN, flit_count SHALL be tied to 0, no counter registers SHALL be instantiated, and all other behaviour SHALL be identical.

Verification
REQ-024 Fill test: DEPTH=4, port 0, credit_i=0, push 5 flits A1..A5 -> credit_o[0]=0 after 4th push, occupancy=4, A5 dropped, overflow[0]=1.
REQ-025 Drain order: then credit_i[0]=1 for 4 cycles -> data_o[0] shows A1,A2,A3,A4 on consecutive cycles, then tx[0]=0 and occupancy=0.
REQ-026 Simultaneous: occupancy=2, rx=1 and credit_i=1 for 10 cycles with data 0..9 -> occupancy stays 2, output order preserved across wrap.
REQ-027 Isolation: continuous push on port 3 with credit_i[3]=0 -> ports 0-2 and 4 keep occupancy=0, overflow=0, tx=0.
REQ-028 Reset mid-op: occupancy[1]=3, assert reset between edges -> occupancy/tx/overflow clear immediately, credit_o=all 1.
REQ-029 Stats (STATS_EN): 70000 accepted pushes on port 2 with drain enabled -> flit_count[2]=16'hFFFF; without the macro -> flit_count=0.
